// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and single-outstanding imem reader feeding IF/ID.
// Define IFU_FAULT_EN to latch imem_rresp errors into if_fault and park in HALT.
module ifu_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_arvalid,
  output logic [ADDR_W-1:0] imem_araddr,
  input  logic              imem_arready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [1:0]        imem_rresp,
  output logic              imem_rready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  input  logic              id_ready,
  output logic              if_fault
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

`ifdef IFU_FAULT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT
  } state_e;
  logic fault_q;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD
  } state_e;
  logic unused_rresp;
  assign unused_rresp = ^imem_rresp;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] ifpc_q;
  logic [DATA_W-1:0] inst_q;
  logic              drop_q;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign tgt    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc_q + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_ADDR;
      araddr_q <= RESET_ADDR;
      ifpc_q   <= RESET_ADDR;
      inst_q   <= NOP;
      drop_q   <= 1'b0;
`ifdef IFU_FAULT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q  <= S_REQ;
          pc_q     <= redirect_valid ? tgt : pc_q;
          araddr_q <= redirect_valid ? tgt : pc_q;
        end
        // araddr is frozen here; a redirect only retargets pc
        S_REQ: begin
          if (redirect_valid) begin
            pc_q   <= tgt;
            drop_q <= 1'b1;
          end
          if (imem_arready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
            if (redirect_valid) begin
              pc_q     <= tgt;
              araddr_q <= tgt;
            end else if (drop_q) begin
              araddr_q <= pc_q;
            end else begin
              ifpc_q  <= pc_q;
              state_q <= S_HOLD;
`ifdef IFU_FAULT_EN
              if (imem_rresp != 2'b00) begin
                inst_q  <= NOP;
                fault_q <= 1'b1;
              end else begin
                inst_q  <= imem_rdata;
              end
`else
              inst_q <= imem_rdata;
`endif
            end
          end else if (redirect_valid) begin
            pc_q   <= tgt;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || id_ready) begin
            state_q  <= S_REQ;
            pc_q     <= redirect_valid ? tgt : pc_inc;
            araddr_q <= redirect_valid ? tgt : pc_inc;
`ifdef IFU_FAULT_EN
            fault_q  <= 1'b0;
            if (fault_q && !redirect_valid) state_q <= S_HALT;
`endif
          end
        end
`ifdef IFU_FAULT_EN
        S_HALT: begin
          if (redirect_valid) begin
            state_q  <= S_REQ;
            pc_q     <= tgt;
            araddr_q <= tgt;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_arvalid = (state_q == S_REQ);
  assign imem_rready  = (state_q == S_WAIT);
  assign if_valid     = (state_q == S_HOLD);
  assign imem_araddr  = araddr_q;
  assign if_pc        = ifpc_q;
  assign if_inst      = inst_q;
`ifdef IFU_FAULT_EN
  assign if_fault     = fault_q;
`else
  assign if_fault     = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: owns the PC, reads instructions from instruction memory over a valid/ready read interface (AR/R style), and drives the fetch side of the IF/ID valid/ready handshake.
- Sits between the imem port and the IF/ID pipeline register; takes branch/jump redirects from EX.
- Non-pipelined: at most one outstanding imem read.

Parameters:
RESET_ADDR, 32'h8000_0000, PC value after reset
ADDR_W, 32, PC / araddr width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
redirect_valid  in  1  EX requests PC change this cycle
redirect_pc  in  ADDR_W  target PC (word aligned)
imem_arvalid  out  1  read request valid
imem_araddr  out  ADDR_W  read address
imem_arready  in  1  request accepted
imem_rvalid  in  1  read data valid
imem_rdata  in  DATA_W  instruction word
imem_rresp  in  2  response code (used only with IFU_FAULT_EN)
imem_rready  out  1  fetch accepts read data
if_pc  out  ADDR_W  PC of presented instruction
if_inst  out  DATA_W  presented instruction
if_valid  out  1  instruction valid to IF/ID
id_ready  in  1  IF/ID accepts instruction
if_fault  out  1  access fault flag (only with IFU_FAULT_EN)

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE, pc=RESET_ADDR, drop=0, imem_arvalid=0, imem_rready=0, if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=RESET_ADDR, if_fault=0. Reset mid-transaction discards all in-flight state; any later imem_rvalid is ignored while in IDLE/REQ.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- States:
  - IDLE: next edge -> REQ.
  - REQ: imem_arvalid=1, imem_araddr=pc. On arready -> WAIT. arvalid/araddr are held stable until accepted; a redirect here does not change araddr.
  - WAIT: imem_rready=1. On rvalid: if drop=1, discard data, clear drop, -> REQ; else latch if_inst=rdata, if_pc=pc, -> HOLD.
  - HOLD: if_valid=1. On id_ready: pc <= pc+4, -> REQ.
- Redirect handling (redirect_valid=1), by state:
  - IDLE/REQ/WAIT: pc <= redirect_pc. In REQ or WAIT, also set drop=1 so the in-flight response is discarded. If redirect and arready coincide in REQ, drop=1 still applies.
  - HOLD without id_ready: discard the held instruction (if_valid falls next edge), pc <= redirect_pc, -> REQ.
  - HOLD with id_ready in the same cycle: the transfer completes (ID/EX squash it), pc <= redirect_pc (not pc+4), -> REQ.
  - WAIT with a simultaneous rvalid: the response is dropped, drop stays clear, pc <= redirect_pc, -> REQ.
- PC arithmetic: pc+4 modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0). Low two bits of redirect_pc are forced to 0.
- Minimum latency: 3 cycles per instruction (REQ, WAIT, HOLD) with arready/rvalid/id_ready all constantly 1. First arvalid appears after the first edge with rst_n=1.

Optional Feature:
- Macro IFU_FAULT_EN.
- Defined:
  - imem_rresp != 0 on an accepted, non-dropped response latches if_fault=1 and if_inst=NOP, then -> HOLD.
  - After that handshake completes -> HALT state. HALT issues no requests and leaves HALT only on redirect_valid (-> REQ).
  - if_fault clears when the faulted instruction is handed off.
- Undefined: imem_rresp ignored, if_fault tied 0, no HALT state.

Test Plan:
- Reset then arready=rvalid=id_ready=1, rdata=pc-derived -> araddr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; if_valid pulses every 3 cycles with matching if_pc/if_inst.
- id_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_inst stable; no new arvalid; resumes at pc+4 when id_ready=1.
- Redirect to 0x8000_0100 in WAIT, then rvalid with 0xDEAD_BEEF -> data never presented; next araddr=0x8000_0100.
- Redirect to 0x8000_0200 in HOLD with id_ready=0 -> if_valid drops; next araddr=0x8000_0200. With id_ready=1 in the same cycle -> handoff occurs; next araddr=0x8000_0200.
- arready held 0 for 4 cycles, redirect in cycle 2 -> araddr stays at the old PC until accepted; the response is dropped; then fetch from the redirect target. pc=0xFFFF_FFFC advance -> next araddr=0x0000_0000.
- IFU_FAULT_EN, rresp=2'b10 -> if_fault=1, if_inst=0x0000_0013; after handoff no arvalid until redirect to 0x8000_0000, then fetch resumes.
